// File: rtl/sdram_bist_pkg.sv
// Shared types and helpers for the SDRAM AXI-Lite memory self-test.
package sdram_bist_pkg;

    typedef enum logic [2:0] {
        IDLE,
        WR,
        WR_RESP,
        RD,
        RD_DATA,
        DONE
    } bist_state_t;

    localparam logic [31:0] LFSR_TAPS = 32'h80200003;
    localparam logic [1:0]  RESP_OKAY = 2'b00;

    function automatic logic [31:0] lfsr_next(input logic [31:0] v);
        return (v >> 1) ^ (v[0] ? LFSR_TAPS : 32'h0000_0000);
    endfunction

endpackage

// File: rtl/taxi_axil_if.sv
// AXI-Lite bundle shared between the self-test manager and the SDRAM controller.
interface taxi_axil_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 32,
    parameter int STRB_W = DATA_W / 8
) ();
    logic [ADDR_W-1:0] awaddr;
    logic [2:0]        awprot;
    logic              awvalid;
    logic              awready;
    logic [DATA_W-1:0] wdata;
    logic [STRB_W-1:0] wstrb;
    logic              wvalid;
    logic              wready;
    logic [1:0]        bresp;
    logic              bvalid;
    logic              bready;
    logic [ADDR_W-1:0] araddr;
    logic [2:0]        arprot;
    logic              arvalid;
    logic              arready;
    logic [DATA_W-1:0] rdata;
    logic [1:0]        rresp;
    logic              rvalid;
    logic              rready;

    modport man (
        output awaddr, awprot, awvalid, input awready,
        output wdata, wstrb, wvalid, input wready,
        input bresp, bvalid, output bready,
        output araddr, arprot, arvalid, input arready,
        input rdata, rresp, rvalid, output rready
    );

    modport sub (
        input awaddr, awprot, awvalid, output awready,
        input wdata, wstrb, wvalid, output wready,
        output bresp, bvalid, input bready,
        input araddr, arprot, arvalid, output arready,
        output rdata, rresp, rvalid, input rready
    );
endinterface

// File: rtl/sdram_axil_bist.sv
// Write-then-readback AXI-Lite memory test: LFSR pattern over a word range,
// reports pass, saturating error count and first failing address.
module sdram_axil_bist
    import sdram_bist_pkg::*;
#(
    parameter int ADDR_W  = 32,
    parameter int COUNT_W = 16,
    parameter int ERR_W   = 16
) (
    input  logic               clk,
    input  logic               rst_n,
    taxi_axil_if.man           axi_if,
    input  logic               start,
    input  logic [ADDR_W-1:0]  base_addr,
    input  logic [COUNT_W-1:0] word_count,
    input  logic [31:0]        seed,
    output logic               busy,
    output logic               done,
    output logic               pass,
    output logic [ERR_W-1:0]   err_count,
    output logic [ADDR_W-1:0]  first_err_addr
);

    bist_state_t        r_state;
    bist_state_t        w_next;
    logic [ADDR_W-1:0]  r_base;
    logic [ADDR_W-1:0]  r_addr;
    logic [COUNT_W-1:0] r_count;
    logic [COUNT_W-1:0] r_left;
    logic [31:0]        r_seed;
    logic [31:0]        r_lfsr;
    logic               r_awvalid;
    logic               r_wvalid;
    logic               r_arvalid;
    logic [ERR_W-1:0]   r_err;
    logic [ADDR_W-1:0]  r_first;
    logic               r_pass;

    logic               w_b_hs;
    logic               w_r_hs;
    logic               w_last;
    logic               w_err_hit;
    logic [31:0]        w_seed;
    logic               w_unused_addr_lsbs;

    assign w_b_hs = (r_state == WR_RESP) && axi_if.bvalid;
    assign w_r_hs = (r_state == RD_DATA) && axi_if.rvalid;
    assign w_last = (r_left == COUNT_W'(1));
    assign w_seed = (seed == 32'd0) ? 32'd1 : seed;
    assign w_unused_addr_lsbs = ^base_addr[1:0];

    assign w_err_hit = (w_b_hs && (axi_if.bresp != RESP_OKAY)) ||
                       (w_r_hs && ((axi_if.rdata != r_lfsr) || (axi_if.rresp != RESP_OKAY)));

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    if (start) w_next = (word_count == '0) ? DONE : WR;
            WR:      if ((!r_awvalid || axi_if.awready) && (!r_wvalid || axi_if.wready))
                         w_next = WR_RESP;
            WR_RESP: if (w_b_hs) w_next = w_last ? RD : WR;
            RD:      if (r_arvalid && axi_if.arready) w_next = RD_DATA;
            RD_DATA: if (w_r_hs) w_next = w_last ? DONE : RD;
            DONE:    w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= IDLE;
            r_base    <= '0;
            r_addr    <= '0;
            r_count   <= '0;
            r_left    <= '0;
            r_seed    <= '0;
            r_lfsr    <= '0;
            r_awvalid <= 1'b0;
            r_wvalid  <= 1'b0;
            r_arvalid <= 1'b0;
            r_err     <= '0;
            r_first   <= '0;
            r_pass    <= 1'b0;
        end else begin
            r_state <= w_next;
            case (r_state)
                IDLE: if (start) begin
                    r_base    <= {base_addr[ADDR_W-1:2], 2'b00};
                    r_addr    <= {base_addr[ADDR_W-1:2], 2'b00};
                    r_count   <= word_count;
                    r_left    <= word_count;
                    r_seed    <= w_seed;
                    r_lfsr    <= w_seed;
                    r_err     <= '0;
                    r_first   <= '0;
                    r_pass    <= 1'b0;
                    r_awvalid <= (word_count != '0);
                    r_wvalid  <= (word_count != '0);
                end
                WR: begin
                    if (axi_if.awready) r_awvalid <= 1'b0;
                    if (axi_if.wready)  r_wvalid  <= 1'b0;
                end
                WR_RESP: if (w_b_hs) begin
                    if (w_last) begin
                        r_addr <= r_base;
                        r_lfsr <= r_seed;
                        r_left <= r_count;
                    end else begin
                        r_addr    <= r_addr + ADDR_W'(4);
                        r_lfsr    <= lfsr_next(r_lfsr);
                        r_left    <= r_left - COUNT_W'(1);
                        r_awvalid <= 1'b1;
                        r_wvalid  <= 1'b1;
                    end
                end
                // First read enters with arvalid low: one turnaround cycle after the reload.
                RD: begin
                    if (!r_arvalid)          r_arvalid <= 1'b1;
                    else if (axi_if.arready) r_arvalid <= 1'b0;
                end
                RD_DATA: if (w_r_hs && !w_last) begin
                    r_addr    <= r_addr + ADDR_W'(4);
                    r_lfsr    <= lfsr_next(r_lfsr);
                    r_left    <= r_left - COUNT_W'(1);
                    r_arvalid <= 1'b1;
                end
                DONE:    r_pass <= (r_err == '0);
                default: ;
            endcase
            if (w_err_hit) begin
                if (r_err != '1) r_err <= r_err + ERR_W'(1);
                if (r_err == '0) r_first <= r_addr;
            end
        end
    end

    assign busy           = (r_state == WR) || (r_state == WR_RESP) ||
                            (r_state == RD) || (r_state == RD_DATA);
    assign done           = (r_state == DONE);
    assign pass           = (r_state == DONE) ? (r_err == '0) : r_pass;
    assign err_count      = r_err;
    assign first_err_addr = r_first;

    assign axi_if.awaddr  = r_addr;
    assign axi_if.awprot  = 3'b000;
    assign axi_if.awvalid = r_awvalid;
    assign axi_if.wdata   = r_lfsr;
    assign axi_if.wstrb   = '1;
    assign axi_if.wvalid  = r_wvalid;
    assign axi_if.bready  = (r_state == WR_RESP);
    assign axi_if.araddr  = r_addr;
    assign axi_if.arprot  = 3'b000;
    assign axi_if.arvalid = r_arvalid;
    assign axi_if.rready  = (r_state == RD_DATA);

endmodule

// File: tb/tb_sdram_axil_bist.sv
// Bench for sdram_axil_bist: reactive AXI-Lite memory plus queue scoreboard.
module tb_sdram_axil_bist;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic [31:0] base_addr;
    logic [15:0] word_count;
    logic [31:0] seed;
    logic        busy, done, pass;
    logic [15:0] err_count;
    logic [31:0] first_err_addr;

    always #5 clk = ~clk;

    taxi_axil_if #(.DATA_W(32), .ADDR_W(32)) axil ();

    sdram_axil_bist #(.ADDR_W(32), .COUNT_W(16), .ERR_W(16)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .axi_if         (axil),
        .start          (start),
        .base_addr      (base_addr),
        .word_count     (word_count),
        .seed           (seed),
        .busy           (busy),
        .done           (done),
        .pass           (pass),
        .err_count      (err_count),
        .first_err_addr (first_err_addr)
    );

    typedef struct {
        logic [15:0] err;
        logic [31:0] first;
        logic        pass;
    } res_t;

    int          checks   = 0;
    int          failures = 0;
    logic [63:0] exp_wr[$];
    logic [31:0] exp_rd[$];
    res_t        exp_res[$];
    logic [31:0] mem [logic [31:0]];

    int          aw_delay      = 0;
    int          rresp_err_idx = -1;
    logic        flip_en       = 1'b0;
    logic [31:0] flip_addr     = '0;
    int          aw_cnt, w_cnt, rd_idx, valid_seen;

    task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    function automatic logic [31:0] model_lfsr(input logic [31:0] x);
        return {1'b0, x[31:1]} ^ ({32{x[0]}} & 32'h80200003);
    endfunction

    // Subordinate: handshakes sampled at negedge, responses applied just after posedge.
    initial begin : responder
        logic        hs_aw, hs_w, hs_b, hs_ar, hs_r;
        logic        pend_aw, pend_w, aw_hold_v, w_hs_prev;
        logic [31:0] pend_addr, pend_data, aw_hold, ar_addr, e_rd;
        logic [63:0] e_wr;
        int          aw_wait;
        pend_aw = 0; pend_w = 0; aw_hold_v = 0; w_hs_prev = 0; aw_wait = 0;
        pend_addr = '0; pend_data = '0; aw_hold = '0; ar_addr = '0;
        axil.awready = 1'b1; axil.wready = 1'b1; axil.arready = 1'b1;
        axil.bvalid = 1'b0; axil.bresp = 2'b00;
        axil.rvalid = 1'b0; axil.rresp = 2'b00; axil.rdata = '0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                pend_aw = 0; pend_w = 0; aw_hold_v = 0; w_hs_prev = 0; aw_wait = 0;
                axil.bvalid = 1'b0; axil.rvalid = 1'b0;
                axil.awready = (aw_delay == 0);
                continue;
            end
            hs_aw = axil.awvalid && axil.awready;
            hs_w  = axil.wvalid  && axil.wready;
            hs_b  = axil.bvalid  && axil.bready;
            hs_ar = axil.arvalid && axil.arready;
            hs_r  = axil.rvalid  && axil.rready;
            if (axil.awvalid || axil.wvalid || axil.arvalid) valid_seen++;
            if (aw_hold_v && axil.awvalid) check_eq("awaddr_stable", axil.awaddr, aw_hold);
            if (aw_hold_v) check_eq("awvalid_held", axil.awvalid, 1);
            aw_hold_v = axil.awvalid && !axil.awready;
            aw_hold   = axil.awaddr;
            if (w_hs_prev) check_eq("wvalid_drop", axil.wvalid, 0);
            w_hs_prev = hs_w;
            if (axil.awvalid && !axil.awready) aw_wait++;
            if (hs_aw) begin
                aw_cnt++; pend_aw = 1; pend_addr = axil.awaddr;
                check_eq("awprot", axil.awprot, 0);
            end
            if (hs_w) begin
                w_cnt++; pend_w = 1; pend_data = axil.wdata;
                check_eq("wstrb", axil.wstrb, 4'hF);
            end
            if (hs_ar) begin
                ar_addr = axil.araddr;
                check_eq("arprot", axil.arprot, 0);
            end
            @(posedge clk);
            #1;
            if (!rst_n) continue;
            if (hs_b) axil.bvalid = 1'b0;
            if (pend_aw && pend_w) begin
                mem[pend_addr] = pend_data;
                check_eq("wr_expected", exp_wr.size() > 0, 1);
                if (exp_wr.size() > 0) begin
                    e_wr = exp_wr.pop_front();
                    check_eq("wr_addr", pend_addr, e_wr[63:32]);
                    check_eq("wr_data", pend_data, e_wr[31:0]);
                end
                pend_aw = 0; pend_w = 0;
                axil.bvalid = 1'b1; axil.bresp = 2'b00;
            end
            if (hs_r) axil.rvalid = 1'b0;
            if (hs_ar) begin
                check_eq("rd_expected", exp_rd.size() > 0, 1);
                if (exp_rd.size() > 0) begin
                    e_rd = exp_rd.pop_front();
                    check_eq("rd_addr", ar_addr, e_rd);
                end
                axil.rdata  = mem.exists(ar_addr) ? mem[ar_addr] : 32'h0;
                if (flip_en && ar_addr == flip_addr) axil.rdata[0] = ~axil.rdata[0];
                axil.rresp  = (rd_idx == rresp_err_idx) ? 2'b10 : 2'b00;
                axil.rvalid = 1'b1;
                rd_idx++;
            end
            if (aw_delay == 0)  axil.awready = 1'b1;
            else if (hs_aw)     begin aw_wait = 0; axil.awready = 1'b0; end
            else                axil.awready = (aw_wait >= aw_delay);
        end
    end

    task automatic check_idle(input string tag);
        check_eq({tag, "_done"},    done, 0);
        check_eq({tag, "_busy"},    busy, 0);
        check_eq({tag, "_pass"},    pass, 0);
        check_eq({tag, "_err"},     err_count, 0);
        check_eq({tag, "_first"},   first_err_addr, 0);
        check_eq({tag, "_awvalid"}, axil.awvalid, 0);
        check_eq({tag, "_wvalid"},  axil.wvalid, 0);
        check_eq({tag, "_arvalid"}, axil.arvalid, 0);
        check_eq({tag, "_bready"},  axil.bready, 0);
        check_eq({tag, "_rready"},  axil.rready, 0);
    endtask

    task automatic load_expect(input logic [31:0] b, input logic [15:0] n, input logic [31:0] s);
        logic [31:0] l, a;
        l = (s == 0) ? 32'd1 : s;
        a = {b[31:2], 2'b00};
        for (int unsigned k = 0; k < n; k++) begin
            exp_wr.push_back({a, l});
            exp_rd.push_back(a);
            l = model_lfsr(l);
            a = a + 32'd4;
        end
        aw_cnt = 0; w_cnt = 0; rd_idx = 0; valid_seen = 0;
        axil.awready = (aw_delay == 0);
    endtask

    task automatic run(input string tag, input logic [31:0] b, input logic [15:0] n,
                       input logic [31:0] s, input logic [15:0] e_err,
                       input logic [31:0] e_first, input int e_cyc);
        res_t r;
        int   cyc;
        load_expect(b, n, s);
        exp_res.push_back('{err: e_err, first: e_first, pass: (e_err == 0)});
        @(posedge clk); #1;
        base_addr = b; word_count = n; seed = s; start = 1'b1;
        cyc = 0;
        while (cyc < 2000) begin
            @(posedge clk); #1;
            cyc++;
            if (cyc == 1) begin
                start = 1'b0;
                check_eq({tag, "_busy_t1"},    busy, n != 0);
                check_eq({tag, "_awvalid_t1"}, axil.awvalid, n != 0);
                check_eq({tag, "_wvalid_t1"},  axil.wvalid, n != 0);
            end
            if (done) break;
        end
        check_eq({tag, "_done_seen"}, done, 1);
        if (e_cyc >= 0) check_eq({tag, "_done_cycle"}, cyc, e_cyc);
        r = exp_res.pop_front();
        check_eq({tag, "_err"},   err_count, r.err);
        check_eq({tag, "_first"}, first_err_addr, r.first);
        check_eq({tag, "_pass"},  pass, r.pass);
        check_eq({tag, "_aw_cnt"}, aw_cnt, n);
        check_eq({tag, "_w_cnt"},  w_cnt, n);
        check_eq({tag, "_rd_cnt"}, rd_idx, n);
        if (n == 0) check_eq({tag, "_no_valid"}, valid_seen, 0);
        @(posedge clk); #1;
        check_eq({tag, "_done_pulse"}, done, 0);
        check_eq({tag, "_pass_held"},  pass, r.pass);
        check_eq({tag, "_busy_after"}, busy, 0);
    endtask

    initial begin : main
        int wait_cyc;
        rst_n = 1'b0; start = 1'b0; base_addr = '0; word_count = '0; seed = '0;
        repeat (3) @(posedge clk);
        #1;
        check_idle("reset");
        rst_n = 1'b1;

        run("func", 32'h100, 16'd4, 32'd1, 16'd0, 32'h0, 18);

        flip_en = 1'b1; flip_addr = 32'h108;
        run("mismatch", 32'h100, 16'd4, 32'd1, 16'd1, 32'h108, 18);
        flip_en = 1'b0;

        run("zero", 32'h100, 16'd0, 32'd1, 16'd0, 32'h0, 1);

        aw_delay = 3;
        run("backpressure", 32'h300, 16'd3, 32'h0000ACE1, 16'd0, 32'h0, -1);
        aw_delay = 0;

        rresp_err_idx = 0;
        run("rresp", 32'h400, 16'd4, 32'd0, 16'd1, 32'h400, 18);
        rresp_err_idx = -1;

        run("wrap", 32'hFFFF_FFFA, 16'd4, 32'd7, 16'd0, 32'h0, 18);

        // Abort a run while a read address is on the bus.
        load_expect(32'h200, 16'd4, 32'd5);
        @(posedge clk); #1;
        base_addr = 32'h200; word_count = 16'd4; seed = 32'd5; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        wait_cyc = 0;
        while (!axil.arvalid && wait_cyc < 200) begin
            @(posedge clk); #1;
            wait_cyc++;
        end
        check_eq("midrd_arvalid_seen", axil.arvalid, 1);
        #1 rst_n = 1'b0;
        #1 check_idle("midrd_rst");
        exp_wr.delete(); exp_rd.delete();
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;

        run("post_rst", 32'h200, 16'd4, 32'd5, 16'd0, 32'h0, 18);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
